// File: rtl/blockmem_pkg.sv
// Shared types and sizing helpers for the dual-pointer block memory.
package blockmem_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/blockmem_ptr.sv
// Modulo-DEPTH pointer register: synchronous clear, then increment, then reset.
module blockmem_ptr
    import blockmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    output logic [ADDR_WIDTH-1:0] ptr_o,
    output logic                  wrap_c_o
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    // Increment beats pointer reset; clear-engine completion beats both.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end else if (rst_i) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o    = ptr_q;
    assign wrap_c_o = inc_i && !clr_i && (ptr_q == PTR_MAX);

endmodule

// File: rtl/blockmem_2r1w_dualptr.sv
// Dual-pointer block memory: pointer-addressed write, external and pointer read ports,
// and a sequential clear engine that zeroes the array one word per cycle.
module blockmem_2r1w_dualptr
    import blockmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_addr0,
    output logic [DATA_WIDTH-1:0] read_data0,
    output logic [DATA_WIDTH-1:0] read_data1,
    input  logic                  wr_rst,
    input  logic                  wr_cs,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  rd_rst,
    input  logic                  rd_inc,
    input  logic                  clear,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  wr_wrap
);

    localparam int unsigned           DEPTH    = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  busy_q;
    logic                  wr_wrap_q;
    logic                  wr_wrap_d;
    logic [DATA_WIDTH-1:0] read_data0_q;
    logic [DATA_WIDTH-1:0] read_data1_q;

    logic [ADDR_WIDTH-1:0] wr_ptr_c;
    logic [ADDR_WIDTH-1:0] rd_ptr_c;
    logic                  wr_wrap_pulse_c;
    logic                  rd_wrap_pulse_c;
    logic                  clr_done_c;
    logic                  wr_en_c;
    logic                  wr_cs_en_c;
    logic                  wr_rst_en_c;
    logic                  rd_inc_en_c;
    logic                  rd_rst_en_c;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_waddr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    // Host-side controls are masked for the whole clear sweep.
    assign wr_en_c     = wr     && !busy_q;
    assign wr_cs_en_c  = wr_cs  && !busy_q;
    assign wr_rst_en_c = wr_rst && !busy_q;
    assign rd_inc_en_c = rd_inc && !busy_q;
    assign rd_rst_en_c = rd_rst && !busy_q;
    assign clr_done_c  = (state_q == ST_CLEAR) && (clr_addr_q == ADDR_MAX);

    blockmem_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk      (clk),
        .rst_n    (reset_n),
        .inc_i    (wr_cs_en_c),
        .rst_i    (wr_rst_en_c),
        .clr_i    (clr_done_c),
        .ptr_o    (wr_ptr_c),
        .wrap_c_o (wr_wrap_pulse_c)
    );

    blockmem_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk      (clk),
        .rst_n    (reset_n),
        .inc_i    (rd_inc_en_c),
        .rst_i    (rd_rst_en_c),
        .clr_i    (clr_done_c),
        .ptr_o    (rd_ptr_c),
        .wrap_c_o (rd_wrap_pulse_c)
    );

    // Clear sequencer: one word per cycle, busy drops with the last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
                    if (clr_done_c) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky wrap flag; a new wrap in the same cycle wins over clearing.
    always_comb begin
        wr_wrap_d = wr_wrap_q;
        if (wr_wrap_pulse_c) begin
            wr_wrap_d = 1'b1;
        end else if (clr_done_c || (wr_rst_en_c && !wr_cs_en_c)) begin
            wr_wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_wrap_q <= 1'b0;
        end else begin
            wr_wrap_q <= wr_wrap_d;
        end
    end

    // Single write port shared between the host and the clear engine.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_ptr_c;
        mem_wdata_c = write_data;
        if (state_q == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = clr_addr_q;
            mem_wdata_c = '0;
        end else if (wr_en_c) begin
            mem_we_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Read-first: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data0_q <= '0;
            read_data1_q <= '0;
        end else begin
            read_data0_q <= mem[read_addr0];
            read_data1_q <= mem[rd_ptr_c];
        end
    end

    assign read_data0 = read_data0_q;
    assign read_data1 = read_data1_q;
    assign busy       = busy_q;
    assign wr_ptr     = wr_ptr_c;
    assign rd_ptr     = rd_ptr_c;
    assign wr_wrap    = wr_wrap_q;

endmodule

// File: tb/tb_blockmem_2r1w_dualptr.sv
// Directed bench for blockmem_2r1w_dualptr at DEPTH=16 with hand-computed expectations.
module tb_blockmem_2r1w_dualptr;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] read_addr0;
    logic [DW-1:0] read_data0;
    logic [DW-1:0] read_data1;
    logic          wr_rst;
    logic          wr_cs;
    logic          wr;
    logic [DW-1:0] write_data;
    logic          rd_rst;
    logic          rd_inc;
    logic          clear;
    logic          busy;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_wrap;

    int n_checks;
    int n_errors;
    int busy_cnt;
    int guard;

    blockmem_2r1w_dualptr #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_addr0 (read_addr0),
        .read_data0 (read_data0),
        .read_data1 (read_data1),
        .wr_rst     (wr_rst),
        .wr_cs      (wr_cs),
        .wr         (wr),
        .write_data (write_data),
        .rd_rst     (rd_rst),
        .rd_inc     (rd_inc),
        .clear      (clear),
        .busy       (busy),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .wr_wrap    (wr_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_rst = 1'b0; wr_cs = 1'b0; wr = 1'b0; write_data = '0;
        rd_rst = 1'b0; rd_inc = 1'b0; clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        read_addr0 = '0;
        reset_n    = 1'b0;
        #23;
        check("rst_rd0",   read_data0, 32'h0);
        check("rst_rd1",   read_data1, 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_wrptr", 32'(wr_ptr), 32'h0);
        check("rst_rdptr", 32'(rd_ptr), 32'h0);
        check("rst_wrap",  32'(wr_wrap), 32'h0);
        reset_n = 1'b1;
        step();

        // Sequential fill 0xA0..0xA3 at addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; wr_cs = 1'b1; write_data = 32'hA0 + 32'(i);
            step();
        end
        idle_inputs();
        check("fill_wrptr", 32'(wr_ptr), 32'h4);
        read_addr0 = 4'd2;
        step();
        check("rd0_addr2", read_data0, 32'hA2);
        check("rd1_ptr0",  read_data1, 32'hA0);

        rd_inc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rd_inc = 1'b0;
        check("rdptr_3", 32'(rd_ptr), 32'h3);
        step();
        check("rd1_ptr3", read_data1, 32'hA3);
        rd_inc = 1'b1; rd_rst = 1'b1;
        step();
        idle_inputs();
        check("rdinc_wins", 32'(rd_ptr), 32'h4);

        // Seed addr 4 and 5, then write addr 5 while reading it.
        wr = 1'b1; wr_cs = 1'b1; write_data = 32'h5555;
        step();
        wr_cs = 1'b0; write_data = 32'h5A5A;
        step();
        check("wr_nocs_hold", 32'(wr_ptr), 32'h5);
        read_addr0 = 4'd5; write_data = 32'h1234;
        step();
        idle_inputs();
        check("read_first_old", read_data0, 32'h5A5A);
        step();
        check("read_after_wr", read_data0, 32'h1234);

        // Advance 5 -> 15, then wrap to 0.
        wr_cs = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("pre_wrap_ptr", 32'(wr_ptr), 32'hF);
        check("pre_wrap_flag", 32'(wr_wrap), 32'h0);
        step();
        wr_cs = 1'b0;
        check("wrap_ptr", 32'(wr_ptr), 32'h0);
        check("wrap_set", 32'(wr_wrap), 32'h1);
        step();
        check("wrap_sticky", 32'(wr_wrap), 32'h1);
        wr_cs = 1'b1; wr_rst = 1'b1;
        step();
        check("wrcs_wins_ptr", 32'(wr_ptr), 32'h1);
        check("wrcs_wins_flag", 32'(wr_wrap), 32'h1);
        wr_cs = 1'b0;
        step();
        wr_rst = 1'b0;
        check("wrrst_ptr", 32'(wr_ptr), 32'h0);
        check("wrrst_flag", 32'(wr_wrap), 32'h0);

        // Clear sweep with host traffic hammering every control during busy.
        wr_cs = 1'b1;
        for (int i = 0; i < 3; i++) step();
        wr_cs = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy_rise", 32'(busy), 32'h1);
        busy_cnt = 1;
        guard    = 0;
        wr = 1'b1; wr_cs = 1'b1; write_data = 32'hFFFF_FFFF; rd_inc = 1'b1; wr_rst = 1'b1; clear = 1'b1;
        while (busy && guard < 100) begin
            step();
            guard++;
            if (busy) busy_cnt++;
        end
        idle_inputs();
        check("clr_busy_len", 32'(busy_cnt), 32'd16);
        check("clr_wrptr", 32'(wr_ptr), 32'h0);
        check("clr_rdptr", 32'(rd_ptr), 32'h0);
        check("clr_wrap",  32'(wr_wrap), 32'h0);
        check("clr_no_restart", 32'(busy), 32'h0);
        for (int a = 0; a < 16; a++) begin
            read_addr0 = AW'(a);
            step();
            check($sformatf("clr_word%0d", a), read_data0, 32'h0);
        end
        check("clr_rd1", read_data1, 32'h0);

        // Asynchronous reset in the middle of a clear sweep.
        wr = 1'b1; wr_cs = 1'b1; write_data = 32'h77;
        step();
        write_data = 32'h78;
        step();
        idle_inputs();
        rd_inc = 1'b1;
        read_addr0 = 4'd1;
        step();
        rd_inc = 1'b0;
        check("pre_rst_rd0", read_data0, 32'h78);
        check("pre_rst_rdptr", 32'(rd_ptr), 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("midclr_busy", 32'(busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy",  32'(busy), 32'h0);
        check("abort_wrptr", 32'(wr_ptr), 32'h0);
        check("abort_rdptr", 32'(rd_ptr), 32'h0);
        check("abort_rd0",   read_data0, 32'h0);
        check("abort_rd1",   read_data1, 32'h0);
        #3;
        reset_n = 1'b1;
        step();
        step();
        check("abort_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/blockmem_2r1w_dualptr.md
# blockmem_2r1w_dualptr

Parametrised dual-pointer block memory: one write port addressed by an internal write pointer and two registered read ports, one at an external address and one at an internal read pointer. It is the generic successor of the team's fixed 256x32 single-pointer memory, used as a sequential message/word buffer in the core datapaths. It adds an independent read pointer, pointer and wrap status outputs, and a sequential memory-clear engine.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 8, address/pointer width; DEPTH = 2**ADDR_WIDTH words
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- read_addr0  input  ADDR_WIDTH  external read address, port 0
- read_data0  output  DATA_WIDTH  registered data at read_addr0
- read_data1  output  DATA_WIDTH  registered data at rd_ptr
- wr_rst  input  1  reset write pointer to 0
- wr_cs  input  1  increment write pointer
- wr  input  1  write write_data at wr_ptr
- write_data  input  DATA_WIDTH  write data
- rd_rst  input  1  reset read pointer to 0
- rd_inc  input  1  increment read pointer
- clear  input  1  start memory clear (single-cycle pulse)
- busy  output  1  clear engine active
- wr_ptr  output  ADDR_WIDTH  current write pointer
- rd_ptr  output  ADDR_WIDTH  current read pointer
- wr_wrap  output  1  sticky: write pointer has wrapped DEPTH-1 -> 0

## Operation
- Reset: wr_ptr, rd_ptr = 0; read_data0/1 = 0; busy = 0; wr_wrap = 0; FSM = IDLE. Memory array not reset.
- Write: if wr, mem[wr_ptr] <= write_data, using pointer value before any same-cycle update.
- Write pointer: wr_cs -> wr_ptr+1 (modulo DEPTH); else wr_rst -> 0; else hold. wr_cs and wr_rst together: increment wins.
- Read pointer: same rules with rd_inc/rd_rst; rd_inc wins over rd_rst.
- wr_wrap: set when wr_ptr advances from DEPTH-1 to 0; cleared by wr_rst (when not overridden by wr_cs) or clear-engine completion; set takes priority in same cycle.
- Reads: read-first; read of address being written returns old contents.
- FSM states IDLE, CLEAR.
  - IDLE -> CLEAR on clear; clr_addr <= 0, busy <= 1.
  - CLEAR: write 0 to mem[clr_addr], clr_addr++; on clr_addr = DEPTH-1 write, go IDLE, busy <= 0, wr_ptr, rd_ptr, wr_wrap <= 0.
  - While busy: wr, wr_cs, wr_rst, rd_inc, rd_rst, clear ignored; read ports keep operating (may see partially cleared data).

## Timing
- Read latency 1 cycle for both ports; read_data1 follows rd_ptr value at the sampling edge.
- Written word visible on a read issued the cycle after the write edge.
- Pointer outputs are registers; updates visible 1 cycle after request.
- Clear: busy rises 1 cycle after clear pulse, stays high exactly DEPTH cycles; pointers read 0 in first IDLE cycle.
- Asynchronous reset mid-clear aborts immediately; memory contents then undefined/partial.

## Structure
- Package blockmem_pkg: FSM state enum (IDLE, CLEAR) and shared pointer-width helper constants.
- One natural sub-module, blockmem_ptr: ADDR_WIDTH pointer register with inc/rst priority and wrap pulse output; instantiated twice (write, read).
- Memory array in top level as a single inferred synchronous RAM.

## Test plan
- Reset then write 0xA0..0xA3 with wr=wr_cs=1 over 4 cycles -> wr_ptr=4, read_addr0=2 gives 0xA2 one cycle later.
- Set rd_inc for 3 cycles after writes above -> rd_ptr=3, read_data1=0xA3; assert rd_inc and rd_rst together -> rd_ptr=4.
- ADDR_WIDTH=4: 16 writes with wr_cs -> wr_ptr=0, wr_wrap=1; wr_rst -> wr_wrap=0.
- Write 0x1234 at addr 5 while read_addr0=5 same cycle -> read_data0 shows old value, next read shows 0x1234.
- Pulse clear with DEPTH=16 -> busy high exactly 16 cycles; writes during busy ignored; afterwards all 16 words read 0, pointers 0.
- Drop reset_n at clear cycle 7 -> busy, pointers, read_data0/1 immediately 0; FSM IDLE.
